fir_serial_mac: RTL and testbench

Parametrised time-multiplexed FIR filter core: a single multiply-accumulate unit iterates over all taps for each input sample. Adds over the fixed 16-bit filter:
- configurable data width, coefficient width and tap count;
- a runtime-writable coefficient bank;
- a valid/ready input handshake;
- round-and-saturate output with an overflow flag.

It sits between the audio sample source and the band summer. Each equaliser band instantiates one core with its own coefficient set.

---
 rtl/fir_serial_mac_if.sv | 28 ++
 rtl/fir_serial_mac.sv | 111 +++++++++++
 tb/tb_fir_serial_mac.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_serial_mac_if.sv
// Sample/coefficient port bundle for one fir_serial_mac core.
// The source side uses master; the core uses slave.
interface fir_serial_mac_if #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int AW      = 6
);
  logic signed [DATA_W-1:0]  filter_in;
  logic                      in_valid;
  logic                      in_ready;
  logic                      coeff_we;
  logic [AW-1:0]             coeff_addr;
  logic signed [COEFF_W-1:0] coeff_wdata;
  logic                      coeff_err;
  logic signed [DATA_W-1:0]  filter_out;
  logic                      out_valid;
  logic                      sat_flag;

  modport master (
    output filter_in, in_valid, coeff_we, coeff_addr, coeff_wdata,
    input  in_ready, coeff_err, filter_out, out_valid, sat_flag
  );

  modport slave (
    input  filter_in, in_valid, coeff_we, coeff_addr, coeff_wdata,
    output in_ready, coeff_err, filter_out, out_valid, sat_flag
  );
endinterface

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR core: one MAC walks all taps per sample,
// then rounds half-up and saturates to DATA_W.
module fir_serial_mac #(
  parameter int DATA_W    = 16,
  parameter int COEFF_W   = 16,
  parameter int N_TAPS    = 64,
  parameter int FRAC_BITS = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_enable,
  fir_serial_mac_if.slave bus
);
  localparam int AW    = $clog2(N_TAPS);
  localparam int PW    = DATA_W + COEFF_W;
  localparam int ACC_W = PW + AW;

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_W:0] MAXV = $signed({{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] MINV = $signed({{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state, state_nx;
  logic [AW-1:0]             wp, k, rd;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  dline [N_TAPS];
  logic signed [COEFF_W-1:0] coef  [N_TAPS];
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W:0]     rsum, rshift;
  logic signed [DATA_W-1:0]  res;
  logic                      res_sat;
  logic                      accept, coef_wr, last_tap;

  assign bus.in_ready = (state == IDLE);
  assign accept       = (state == IDLE) && bus.in_valid;
  assign coef_wr      = (state == IDLE) && bus.coeff_we &&
                        ({1'b0, bus.coeff_addr} < (AW+1)'(N_TAPS));
  assign last_tap     = (k == AW'(N_TAPS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = MAC;
      MAC:     if (last_tap)     state_nx = OUT;
      OUT:                       state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)             state <= IDLE;
    else if (clk_enable) state <= state_nx;
  end

  // wp-k modulo N_TAPS; the AW-bit wrap already handles the power-of-two case
  assign rd   = wp - k + ((wp < k) ? AW'(N_TAPS) : AW'(0));
  assign prod = dline[rd] * coef[k];

  assign rsum   = $signed({acc[ACC_W-1], acc}) + HALF;
  assign rshift = rsum >>> FRAC_BITS;

  always_comb begin
    res     = rshift[DATA_W-1:0];
    res_sat = 1'b0;
    if (rshift > MAXV) begin
      res     = MAXV[DATA_W-1:0];
      res_sat = 1'b1;
    end else if (rshift < MINV) begin
      res     = MINV[DATA_W-1:0];
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      k   <= '0;
      acc <= '0;
      for (int i = 0; i < N_TAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
      bus.filter_out <= '0;
      bus.out_valid  <= 1'b0;
      bus.sat_flag   <= 1'b0;
      bus.coeff_err  <= 1'b0;
    end else if (clk_enable) begin
      bus.out_valid <= (state == OUT);
      bus.coeff_err <= bus.coeff_we && (state != IDLE);
      if (coef_wr) coef[bus.coeff_addr] <= bus.coeff_wdata;
      case (state)
        IDLE: if (accept) begin
          dline[wp] <= bus.filter_in;
          acc       <= '0;
          k         <= '0;
        end
        MAC: begin
          acc <= acc + $signed({{AW{prod[PW-1]}}, prod});
          k   <= last_tap ? AW'(0) : k + AW'(1);
        end
        OUT: begin
          bus.filter_out <= res;
          bus.sat_flag   <= res_sat;
          wp             <= (wp == AW'(N_TAPS - 1)) ? AW'(0) : wp + AW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_serial_mac.sv
// Randomized bench for fir_serial_mac against a sum-of-products model.
module tb_fir_serial_mac;
  localparam int DATA_W    = 16;
  localparam int COEFF_W   = 16;
  localparam int N_TAPS    = 8;
  localparam int FRAC_BITS = 15;
  localparam int AW        = $clog2(N_TAPS);
  localparam longint MAXO  = (longint'(1) << (DATA_W - 1)) - 1;
  localparam longint MINO  = -(longint'(1) << (DATA_W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_enable = 1'b1;
  always #5 clk = ~clk;

  fir_serial_mac_if #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .AW(AW)) bus ();

  fir_serial_mac #(
    .DATA_W(DATA_W), .COEFF_W(COEFF_W), .N_TAPS(N_TAPS), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .bus(bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  longint hist [N_TAPS];
  longint cf   [N_TAPS];
  longint exp_y;
  longint exp_sat;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_TAPS; i++) begin
      hist[i] = 0;
      cf[i]   = 0;
    end
  endfunction

  // y = sat(round(sum c[k]*x[n-k])) with history kept newest-first
  function automatic void model_push(input longint x);
    longint s, r;
    for (int i = N_TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    s = 0;
    for (int i = 0; i < N_TAPS; i++) s += cf[i] * hist[i];
    r = (s + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
    exp_sat = 0;
    if (r > MAXO) begin r = MAXO; exp_sat = 1; end
    else if (r < MINO) begin r = MINO; exp_sat = 1; end
    exp_y = r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wcoef(input int a, input int v);
    chk("wr_in_idle", bus.in_ready, 1);
    bus.coeff_we    = 1'b1;
    bus.coeff_addr  = AW'(a);
    bus.coeff_wdata = COEFF_W'(v);
    step();
    bus.coeff_we = 1'b0;
    cf[a] = v;
    chk("coeff_err_idle", bus.coeff_err, 0);
  endtask

  task automatic accept_s(input longint x);
    int n;
    n = 0;
    bus.filter_in = DATA_W'(x);
    bus.in_valid  = 1'b1;
    while (!(bus.in_ready && clk_enable) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("accept_timeout", n, 0);
    step();
    bus.in_valid = 1'b0;
    model_push(x);
  endtask

  // lat counts cycles since the accept cycle (cycle 0)
  task automatic finish_s(input int lat0, input int stall_at, input int stall_len, input bit freeze_out);
    int lat;
    lat = lat0;
    while (!bus.out_valid && lat < 200) begin
      if (lat == stall_at) begin
        clk_enable = 1'b0;
        repeat (stall_len) begin step(); lat++; end
        clk_enable = 1'b1;
      end
      step();
      lat++;
    end
    chk("latency", lat, N_TAPS + 2 + ((stall_at > 0) ? stall_len : 0));
    chk("filter_out", bus.filter_out, exp_y);
    chk("sat_flag", bus.sat_flag, exp_sat);
    chk("ready_at_valid", bus.in_ready, 1);
    if (freeze_out) begin
      clk_enable = 1'b0;
      step();
      step();
      chk("valid_frozen", bus.out_valid, 1);
      clk_enable = 1'b1;
    end
    step();
    chk("valid_pulse", bus.out_valid, 0);
    chk("out_hold", bus.filter_out, exp_y);
  endtask

  task automatic send(input longint x);
    accept_s(x);
    finish_s(1, 0, 0, 1'b0);
  endtask

  initial begin
    longint q[$];
    longint x;
    int last, seen, v;
    bit a;

    bus.filter_in   = '0;
    bus.in_valid    = 1'b0;
    bus.coeff_we    = 1'b0;
    bus.coeff_addr  = '0;
    bus.coeff_wdata = '0;
    model_reset();

    repeat (3) step();
    chk("rst_filter_out", bus.filter_out, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sat_flag", bus.sat_flag, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_coeff_err", bus.coeff_err, 0);
    rst = 1'b0;
    step();

    // impulse: c[k]=(k+1)*1024, x=32 -> outputs 1..8 then 0
    for (int k = 0; k < N_TAPS; k++) wcoef(k, (k + 1) * 1024);
    for (int i = 0; i <= N_TAPS; i++) send(i == 0 ? 32 : 0);

    // write while busy is dropped; the impulse readback shows c unchanged
    accept_s(longint'($urandom_range(0, 2000)));
    step();
    step();
    bus.coeff_we    = 1'b1;
    bus.coeff_addr  = AW'(0);
    bus.coeff_wdata = COEFF_W'(12345);
    step();
    bus.coeff_we = 1'b0;
    chk("coeff_err_pulse", bus.coeff_err, 1);
    step();
    chk("coeff_err_clear", bus.coeff_err, 0);
    finish_s(5, 0, 0, 1'b0);
    for (int i = 0; i < N_TAPS; i++) send(i == 0 ? 32 : 0);

    // write and accept in the same cycle: the new c[0] is used
    v = -2048;
    chk("ready_same_cycle", bus.in_ready, 1);
    bus.coeff_we    = 1'b1;
    bus.coeff_addr  = AW'(0);
    bus.coeff_wdata = COEFF_W'(v);
    bus.filter_in   = DATA_W'(100);
    bus.in_valid    = 1'b1;
    step();
    bus.coeff_we = 1'b0;
    bus.in_valid = 1'b0;
    cf[0] = v;
    model_push(100);
    finish_s(1, 0, 0, 1'b0);

    // rounding: single tap of 0.5
    wcoef(0, 16384);
    for (int k = 1; k < N_TAPS; k++) wcoef(k, 0);
    send(3);
    send(-3);

    // random coefficients and samples with stalls
    for (int k = 0; k < N_TAPS; k++) wcoef(k, int'($urandom_range(0, 8191)) - 4096);
    for (int i = 0; i < 12; i++) begin
      accept_s(longint'($urandom_range(0, 65535)) - 32768);
      finish_s(1, (i % 2 == 0) ? int'($urandom_range(1, N_TAPS)) : 0, 5, (i % 4 == 1));
    end

    // in_valid held high: back-to-back accepts
    last = -1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4 * (N_TAPS + 2); i++) begin
      x = longint'($urandom_range(0, 65535)) - 32768;
      bus.filter_in = DATA_W'(x);
      a = bus.in_ready && clk_enable;
      step();
      if (a) begin
        model_push(x);
        q.push_back(exp_y);
        if (last >= 0) chk("accept_spacing", cyc - last, N_TAPS + 2);
        last = cyc;
      end
      if (bus.out_valid && q.size() > 0) chk("held_out", bus.filter_out, q.pop_front());
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3 * (N_TAPS + 2) && q.size() > 0; i++) begin
      step();
      if (bus.out_valid) chk("held_drain", bus.filter_out, q.pop_front());
    end
    chk("held_drain_left", q.size(), 0);
    step();

    // reset in the third MAC cycle: no output, everything cleared
    accept_s(1234);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("rstmid_out_valid", bus.out_valid, 0);
    chk("rstmid_in_ready", bus.in_ready, 1);
    chk("rstmid_filter_out", bus.filter_out, 0);
    chk("rstmid_sat_flag", bus.sat_flag, 0);
    seen = 0;
    repeat (N_TAPS + 4) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("rstmid_no_valid", seen, 0);
    for (int k = 0; k < N_TAPS; k++) wcoef(k, int'($urandom_range(1, 32767)));
    send(0);

    // saturation, positive then negative
    rst_pulse();
    for (int k = 0; k < N_TAPS; k++) wcoef(k, 32767);
    for (int i = 0; i < 3; i++) send(32767);
    chk("sat_pos_flag", bus.sat_flag, 1);
    rst_pulse();
    for (int k = 0; k < N_TAPS; k++) wcoef(k, 32767);
    for (int i = 0; i < 3; i++) send(-32768);
    chk("sat_neg_flag", bus.sat_flag, 1);
    chk("sat_neg_value", bus.filter_out, MINO);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
